// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the RV32 instruction-fetch stage.
// Holds the bubble encoding, reset PC, FSM encodings and PC step.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST_ENC = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_WAIT  = 2'b10,
        S_FLUSH = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_ent_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry instruction/PC buffer that parks a response while ID stalls.
// Clear wins over write, write wins over read.
module if_hold_buf
    import if_fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  fetch_ent_t wr_ent,
    input  logic       rd,
    input  logic       clr,
    output logic       full,
    output fetch_ent_t ent
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            ent  <= '0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (wr) begin
            full <= 1'b1;
            ent  <= wr_ent;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, imem handshake and IF2ID register.
// Optional macro IF_MISALIGN_CHK_EN adds IF_misalign and halts on bad jumps.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_ENC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_IF,
    input  logic        nop_IF,
    input  logic        jmp_vld_IF,
    input  logic [31:0] jmp_addr_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        IF_inst_vld
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        IF_misalign
`endif
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc;
    logic        vld_reg;
    logic        bubble;

    logic        stall;
    logic        can_issue;
    logic        accept;
    logic        deliver;
    logic        drain;
    logic        buf_wr;

    logic        buf_full;
    fetch_ent_t  buf_ent;
    fetch_ent_t  rsp_ent;

    logic [31:0] jmp_target;
    logic        jmp_mis;
    logic        halted;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q;

    assign jmp_mis     = jmp_addr_IF[1:0] != 2'b00;
    assign jmp_target  = jmp_addr_IF;
    assign halted      = misalign_q;
    assign IF_misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (jmp_vld_IF) begin
            misalign_q <= jmp_mis;
        end
    end
`else
    logic unused_jmp_lsb;

    assign unused_jmp_lsb = ^jmp_addr_IF[1:0];
    assign jmp_mis        = 1'b0;
    assign jmp_target     = {jmp_addr_IF[31:2], 2'b00};
    assign halted         = 1'b0;
`endif

    // A shown bubble over a still-valid entry means ID has not taken it yet.
    assign stall       = hold_IF | nop_IF | (bubble & vld_reg);
    assign can_issue   = ~hold_IF & ~buf_full & ~halted;
    assign imem_addr   = pc;
    assign IF_inst_vld = vld_reg & ~bubble;

    assign deliver = accept & ~stall;
    assign buf_wr  = accept & stall;
    assign drain   = buf_full & ~stall & ~jmp_vld_IF;

    assign rsp_ent.inst = imem_rdata;
    assign rsp_ent.pc   = pc;

    if_hold_buf u_hold_buf (
        .clk    (clk),
        .rst    (rst),
        .wr     (buf_wr),
        .wr_ent (rsp_ent),
        .rd     (drain),
        .clr    (jmp_vld_IF),
        .full   (buf_full),
        .ent    (buf_ent)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = can_issue;
                if (can_issue && imem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Redirect: any response in flight belongs to the old path.
        if (jmp_vld_IF) begin
            accept = 1'b0;
            case (state)
                S_WAIT, S_FLUSH: begin
                    state_nxt = imem_rvalid ? S_REQ : S_FLUSH;
                end
                S_REQ: begin
                    state_nxt = (can_issue && imem_gnt) ? S_FLUSH : S_REQ;
                end
                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            IF_inst <= NOP_INST;
            IF_pc   <= '0;
            vld_reg <= 1'b0;
            bubble  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (jmp_vld_IF) begin
                pc      <= jmp_target;
                IF_inst <= NOP_INST;
                vld_reg <= 1'b0;
                bubble  <= 1'b0;
                if (jmp_mis) begin
                    IF_pc <= jmp_addr_IF;
                end
            end else begin
                bubble <= nop_IF;
                if (accept) begin
                    pc <= pc_next(pc);
                end
                if (deliver) begin
                    IF_inst <= imem_rdata;
                    IF_pc   <= pc;
                    vld_reg <= 1'b1;
                end else if (drain) begin
                    IF_inst <= buf_ent.inst;
                    IF_pc   <= buf_ent.pc;
                    vld_reg <= 1'b1;
                end else if (!stall) begin
                    vld_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32 pipeline; owns the PC and the instruction-memory request handshake.
- Drives the IF2ID register (IF_inst, IF_pc, IF_inst_vld) that ID decodes.
- Obeys the hazard controller's hold_IF, nop_IF and jmp_vld_IF/jmp_addr_IF; at most one outstanding imem request.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
hold_IF  in  1  freeze PC and IF2ID contents
nop_IF  in  1  present bubble to ID next cycle, keep held instruction
jmp_vld_IF  in  1  redirect PC this cycle
jmp_addr_IF  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  fetched instruction
IF_inst  out  32  instruction to ID
IF_pc  out  32  PC of IF_inst
IF_inst_vld  out  1  IF_inst valid

Behaviour:
- One clock, clk; rst synchronous, active-high, sampled on posedge clk.
- Reset values: pc=RESET_PC, state=S_IDLE, imem_req=0, IF_inst=NOP_INST, IF_pc=0, IF_inst_vld=0, holding buffer empty, bubble flag=0.
- rst mid-transaction: everything returns to reset values; any later imem_rvalid for the abandoned request is ignored.
- FSM states S_IDLE, S_REQ, S_WAIT, S_FLUSH:
  - S_IDLE: exactly one cycle after rst deasserts, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc, unless hold_IF=1 or the buffer is full (then imem_req=0). On imem_gnt go to S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid: if neither hold_IF nor nop_IF, load IF_inst=imem_rdata, IF_pc=pc, vld=1; otherwise write the holding buffer. In both cases pc<=pc+4 (mod 2^32 wrap) and go to S_REQ.
  - S_FLUSH: imem_req=0. Drop the next imem_rvalid, then go to S_REQ.
- Holding buffer: one entry (inst, pc). It drains into IF2ID in the first cycle with hold_IF=0 and nop_IF=0. While it is full, no new request is issued, so it never overflows.
- No instruction is ever delivered twice or lost except by a redirect.
- hold_IF=1: IF_inst, IF_pc and the vld register are unchanged next cycle; pc does not advance except on a response captured into the buffer.
- nop_IF=1: same as hold, plus the bubble flag is set for the next cycle.
  - IF_inst_vld = vld_reg & ~bubble.
  - When hold_IF and nop_IF are both high, the held instruction reappears valid once both drop.
- jmp_vld_IF=1 (priority over hold_IF and nop_IF):
  - pc<=jmp_addr_IF; buffer cleared; IF_inst_vld=0 and IF_inst=NOP_INST next cycle.
  - In S_WAIT with no same-cycle rvalid: go to S_FLUSH.
  - In S_WAIT with a same-cycle rvalid: drop the data and go to S_REQ.
  - In S_REQ with a same-cycle gnt: go to S_FLUSH, since the granted request is stale.
  - Otherwise: go to S_REQ.
  - First fetch of the target has imem_req=1 in the cycle after the jump.
  - A second jump in S_FLUSH updates pc only; exactly one response is still discarded.
- Latency: gnt+rvalid in consecutive cycles gives an instruction every 2 cycles; IF2ID updates the cycle after rvalid.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined:
  - Adds output IF_misalign (1 bit, reset 0).
  - A jump with jmp_addr_IF[1:0]!=2'b00 sets IF_misalign=1 and IF_pc=jmp_addr_IF with IF_inst_vld=0.
  - Fetching halts in S_REQ with imem_req=0 until a new aligned jump or rst.
- Undefined: jmp_addr_IF[1:0] is ignored and the PC is loaded with {jmp_addr_IF[31:2],2'b00}.

Decomposition:
- Add to defines.v: NOP_INST encoding, RESET_PC default, FSM state encodings (2-bit), PC increment constant 4.
- One sub-module, if_hold_buf: 1-entry inst/pc buffer with wr/rd/clr/full.

Test Plan:
- Reset release, gnt and rvalid each 1 cycle after req, rdata=0x00500093 -> first req at 0x0 in the 2nd cycle after rst; IF_inst=0x00500093, IF_pc=0, vld=1; next imem_addr=0x4.
- rvalid arrives while hold_IF=1 for 3 cycles -> IF2ID unchanged and imem_req=0 during the hold; buffered instruction appears with IF_pc=0x4 the cycle after hold drops.
- hold_IF=nop_IF=1 for 1 cycle with IF_inst=0x00A00113 -> IF_inst_vld=0 for one cycle, then 0x00A00113 valid again; no request repeated.
- Jump to 0x100 while in S_WAIT, stale rvalid 2 cycles later -> stale data never seen, vld=0 until the 0x100 response, imem_addr=0x100.
- Jump to 0x200 in the same cycle as imem_gnt -> S_FLUSH, one response discarded, next req at 0x200.
- rst asserted mid-S_WAIT, rvalid arrives during reset -> all outputs at reset values; first post-reset req at RESET_PC.
